pq_cmd_driver: RTL and testbench
================================

Name: pq_cmd_driver

Overview:
- Initiator-side driver for the priority-queue command interface (i_wrt/i_read/i_data in, o_full/o_empty/o_data out) used by the hybrid/BRAM-tree max-queues.
- Converts independent valid/ready push and pop streams into correctly spaced queue commands.
- Merges a simultaneous push and pop into one replace, and returns popped values on a valid/ready result stream.
- Tracks queue occupancy locally and enforces the queue's zero-is-empty data convention.

Parameters:
- DATA_WIDTH, 12: payload width.
- QUEUE_SIZE, 28: queue capacity in entries.
- OP_GAP, 4: minimum idle cycles between consecutive queue commands (sort/settle time), at least 1.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- s_push_valid  in  1  push request.
- s_push_ready  out  1  push accepted when valid&&ready.
- s_push_data  in  DATA_WIDTH  value to insert.
- s_pop_valid  in  1  pop request.
- s_pop_ready  out  1  pop accepted when valid&&ready.
- m_pop_valid  out  1  result valid.
- m_pop_ready  in  1  result consumer ready.
- m_pop_data  out  DATA_WIDTH  popped value.
- q_wrt  out  1  to queue i_wrt.
- q_read  out  1  to queue i_read.
- q_data  out  DATA_WIDTH  to queue i_data.
- q_full  in  1  from queue o_full.
- q_empty  in  1  from queue o_empty.
- q_head  in  DATA_WIDTH  from queue o_data (current maximum).
- o_count  out  $clog2(QUEUE_SIZE+1)  local occupancy.
- o_zero_drop  out  1  one-cycle pulse when a zero push is discarded.

Behaviour:
- Interface decisions: one clock (CLK); reset RST is synchronous and active-high.
- Reset values: q_wrt=0, q_read=0, q_data=0, m_pop_valid=0, m_pop_data=0, o_count=0, o_zero_drop=0, state=READY.
- RST mid-operation aborts any cooldown and drops a pending result.
- States:
  - READY: may accept.
  - COOL: counter loaded with OP_GAP, decrements each cycle; returns to READY when it reaches 1.
  - Both ready outputs are 0 in COOL.
- Terms: slot_free = !m_pop_valid || m_pop_ready. full_c = (o_count==QUEUE_SIZE) || q_full. empty_c = (o_count==0).
- Ready outputs are combinational and independent of their own valid:
  - s_push_ready = READY && (!full_c || (s_pop_valid && slot_free && !empty_c)).
  - s_pop_ready = READY && slot_free && (!empty_c || s_push_valid).
- Decision in accept cycle t. Command outputs are registered single-cycle pulses at t+1; the result is registered at t+1.
  - Zero push (push data==0, accepted): discarded; o_zero_drop=1 at t+1; no queue command. A pop accepted in the same cycle is handled as pop-only.
  - Push only: q_wrt=1, q_data=push data; o_count+1; enter COOL.
  - Pop only: q_read=1; m_pop_data=q_head sampled at t; m_pop_valid=1; o_count-1; enter COOL.
  - Push+pop, push data <= q_head, queue non-empty: replace. q_wrt=q_read=1, q_data=push data; result=q_head; o_count unchanged; enter COOL.
  - Push+pop, push data > q_head or queue empty: bypass. result=push data; no queue command; stay READY; o_count unchanged.
- m_pop_valid holds with m_pop_data stable until m_pop_ready. A new result may load in the same cycle the old one is taken.
- q_full disagreeing with the local count: q_full alone blocks push-only. o_count never wraps.
- q_empty is informational only; empty_c is authoritative.
- Throughput: one queue command per OP_GAP+1 cycles; bypass and zero-drop are not throttled.

Decomposition:
- Shared package pq_pkg: state enum (READY, COOL), op-kind enum (NONE, PUSH, POP, REPLACE, BYPASS, DROP), and a count-width function clog2(QUEUE_SIZE+1).
- One sub-module, pq_result_reg: a single-entry valid/ready holding register for the result stream.

Test Plan:
- Reset then push 5, 9, 3, each spaced by the gap: q_wrt pulses at 1-cycle latency, next push_ready only after OP_GAP+1 cycles, o_count=3.
- Queue head 9, pop: q_read pulse at t+1; m_pop_data=9 at t+1; m_pop_valid holds while m_pop_ready=0 for 3 cycles; o_count decrements by 1.
- Head 9, push 4 with pop: one cycle with q_wrt=q_read=1 and q_data=4; result 9; o_count unchanged.
- Head 9, push 12 with pop: no q command, result 12, push_ready high the next cycle.
- Empty queue, push 7 with pop: bypass returns 7; pop alone while empty: s_pop_ready=0.
- Fill to 28: push-only blocked. Push 0: o_zero_drop pulse, count unchanged. RST asserted mid-COOL: all outputs return to reset values the next cycle.

Source files
------------

// File: rtl/pq_pkg.sv
// Shared types and helpers for the priority-queue command driver.
package pq_pkg;

    typedef enum logic {READY, COOL} state_t;

    typedef enum logic [2:0] {NONE, PUSH, POP, REPLACE, BYPASS, DROP} op_t;

    function automatic int count_width(input int queue_size);
        return $clog2(queue_size + 1);
    endfunction

endpackage

// File: rtl/pq_result_reg.sv
// Single-entry valid/ready holding register for popped results.
module pq_result_reg
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    input  logic                  ready
);

    // A load may coincide with the consumer taking the previous entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pq_cmd_driver.sv
// Turns push/pop valid/ready streams into spaced i_wrt/i_read queue commands,
// merging push+pop into a replace or a bypass and returning popped values.
module pq_cmd_driver
    import pq_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int QUEUE_SIZE = 28,
    parameter int OP_GAP     = 4
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 s_push_valid,
    output logic                                 s_push_ready,
    input  logic [DATA_WIDTH-1:0]                s_push_data,
    input  logic                                 s_pop_valid,
    output logic                                 s_pop_ready,
    output logic                                 m_pop_valid,
    input  logic                                 m_pop_ready,
    output logic [DATA_WIDTH-1:0]                m_pop_data,
    output logic                                 q_wrt,
    output logic                                 q_read,
    output logic [DATA_WIDTH-1:0]                q_data,
    input  logic                                 q_full,
    input  logic                                 q_empty,
    input  logic [DATA_WIDTH-1:0]                q_head,
    output logic [count_width(QUEUE_SIZE)-1:0]   o_count,
    output logic                                 o_zero_drop
);

    localparam int                CW       = count_width(QUEUE_SIZE);
    localparam int                GW       = $clog2(OP_GAP + 1);
    localparam logic [CW-1:0]     FULL_CNT = CW'(QUEUE_SIZE);
    localparam logic [GW-1:0]     GAP_LOAD = GW'(OP_GAP);

    state_t          state, state_n;
    logic [GW-1:0]   gap_cnt, gap_cnt_n;
    op_t             op;
    logic            slot_free, full_c, empty_c;
    logic            push_acc, pop_acc, zero_push, is_cmd, res_load;
    logic [DATA_WIDTH-1:0] res_data;

    // The local count is authoritative for emptiness; q_empty is advisory.
    logic unused_q_empty;
    assign unused_q_empty = q_empty;

    always_comb begin
        slot_free    = !m_pop_valid || m_pop_ready;
        full_c       = (o_count == FULL_CNT) || q_full;
        empty_c      = (o_count == '0);
        s_push_ready = (state == READY) && (!full_c || (s_pop_valid && slot_free && !empty_c));
        s_pop_ready  = (state == READY) && slot_free && (!empty_c || s_push_valid);
        push_acc     = s_push_valid && s_push_ready;
        pop_acc      = s_pop_valid && s_pop_ready;
        zero_push    = push_acc && (s_push_data == '0);

        // A pop with nothing to remove returns zero, the queue's empty value.
        op = NONE;
        if (zero_push)
            op = pop_acc ? (empty_c ? BYPASS : POP) : DROP;
        else if (push_acc && pop_acc)
            op = (!empty_c && (s_push_data <= q_head)) ? REPLACE : BYPASS;
        else if (push_acc)
            op = PUSH;
        else if (pop_acc)
            op = empty_c ? BYPASS : POP;

        is_cmd   = (op == PUSH) || (op == POP) || (op == REPLACE);
        res_load = (op == POP) || (op == REPLACE) || (op == BYPASS);
        res_data = (op == BYPASS) ? (push_acc ? s_push_data : '0) : q_head;

        state_n   = state;
        gap_cnt_n = gap_cnt;
        if (state == COOL) begin
            if (gap_cnt == GW'(1))
                state_n = READY;
            else
                gap_cnt_n = gap_cnt - GW'(1);
        end else if (is_cmd) begin
            state_n   = COOL;
            gap_cnt_n = GAP_LOAD;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= READY;
            gap_cnt     <= '0;
            q_wrt       <= 1'b0;
            q_read      <= 1'b0;
            q_data      <= '0;
            o_count     <= '0;
            o_zero_drop <= 1'b0;
        end else begin
            state       <= state_n;
            gap_cnt     <= gap_cnt_n;
            q_wrt       <= (op == PUSH) || (op == REPLACE);
            q_read      <= (op == POP) || (op == REPLACE);
            q_data      <= ((op == PUSH) || (op == REPLACE)) ? s_push_data : '0;
            o_zero_drop <= zero_push;
            if (op == PUSH)
                o_count <= o_count + CW'(1);
            else if (op == POP)
                o_count <= o_count - CW'(1);
        end
    end

    pq_result_reg #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_result (
        .clk       (CLK),
        .rst       (RST),
        .load      (res_load),
        .load_data (res_data),
        .valid     (m_pop_valid),
        .data      (m_pop_data),
        .ready     (m_pop_ready)
    );

endmodule

// File: tb/tb_pq_cmd_driver.sv
// Self-checking bench for pq_cmd_driver with a behavioural max-queue attached.
module tb_pq_cmd_driver;

    localparam int DW  = 12;
    localparam int QS  = 28;
    localparam int GAP = 4;
    localparam int CW  = $clog2(QS + 1);

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          s_push_valid = 1'b0, s_pop_valid = 1'b0, m_pop_ready = 1'b1;
    logic [DW-1:0] s_push_data = '0;
    logic          s_push_ready, s_pop_ready, m_pop_valid;
    logic [DW-1:0] m_pop_data, q_data, q_head;
    logic          q_wrt, q_read, q_full, q_empty, o_zero_drop;
    logic [CW-1:0] o_count;
    logic          full_force = 1'b0;

    always #5 CLK = ~CLK;

    pq_cmd_driver #(.DATA_WIDTH(DW), .QUEUE_SIZE(QS), .OP_GAP(GAP)) dut (
        .CLK(CLK), .RST(RST),
        .s_push_valid(s_push_valid), .s_push_ready(s_push_ready), .s_push_data(s_push_data),
        .s_pop_valid(s_pop_valid), .s_pop_ready(s_pop_ready),
        .m_pop_valid(m_pop_valid), .m_pop_ready(m_pop_ready), .m_pop_data(m_pop_data),
        .q_wrt(q_wrt), .q_read(q_read), .q_data(q_data),
        .q_full(q_full), .q_empty(q_empty), .q_head(q_head),
        .o_count(o_count), .o_zero_drop(o_zero_drop)
    );

    // Behavioural max-queue answering the driver's commands.
    logic [DW-1:0] qmem [0:QS+3];
    int            qsz = 0;
    int            mi_q;
    logic [DW-1:0] head_c;

    always_comb begin
        head_c = '0;
        mi_q   = 0;
        for (int i = 0; i < QS + 4; i++)
            if (i < qsz && qmem[i] > head_c) begin
                head_c = qmem[i];
                mi_q   = i;
            end
    end
    assign q_head  = head_c;
    assign q_full  = (qsz >= QS) || full_force;
    assign q_empty = (qsz == 0);

    always @(posedge CLK) begin
        if (RST) qsz <= 0;
        else if (q_wrt && q_read && qsz > 0) qmem[mi_q] <= q_data;
        else if (q_read && qsz > 0) begin
            qmem[mi_q] <= qmem[qsz-1];
            qsz        <= qsz - 1;
        end else if (q_wrt && qsz < QS + 4) begin
            qmem[qsz] <= q_data;
            qsz       <= qsz + 1;
        end
    end

    // Reference model: contents as a plain list, cooldown as a cycle stamp.
    int            checks = 0, fails = 0;
    int            cyc = 0, next_ok = 0, m_cnt = 0;
    logic [DW-1:0] contents[$];
    bit            e_valid, e_wrt, e_read, e_drop, e_push_ready, e_pop_ready;
    logic [DW-1:0] e_data, e_qdata;

    task automatic model_reset();
        contents.delete();
        m_cnt = 0; e_valid = 0; e_data = '0; e_wrt = 0; e_read = 0; e_drop = 0; e_qdata = '0;
        next_ok = cyc;
    endtask

    task automatic model_ready();
        bit rdy, slot, full, empty;
        rdy   = (cyc >= next_ok);
        empty = (m_cnt == 0);
        slot  = !e_valid || m_pop_ready;
        full  = (m_cnt == QS) || q_full;
        e_push_ready = rdy && (!full || (s_pop_valid && slot && !empty));
        e_pop_ready  = rdy && slot && (!empty || s_push_valid);
    endtask

    task automatic model_step();
        bit pa, pp, res, empty;
        logic [DW-1:0] d, head, rv;
        int mi;
        pa = s_push_valid && e_push_ready;
        pp = s_pop_valid && e_pop_ready;
        d = s_push_data;
        empty = (m_cnt == 0);
        head = '0; mi = 0;
        foreach (contents[i]) if (contents[i] > head) begin head = contents[i]; mi = i; end
        e_wrt = 0; e_read = 0; e_qdata = '0; res = 0; rv = '0;
        e_drop = pa && (d == '0);
        if (e_drop) pa = 0;
        if (pa && pp) begin
            res = 1;
            if (!empty && d <= head) begin
                contents[mi] = d; e_wrt = 1; e_read = 1; e_qdata = d; rv = head;
                next_ok = cyc + GAP + 1;
            end else rv = d;
        end else if (pa) begin
            contents.push_back(d); m_cnt++; e_wrt = 1; e_qdata = d;
            next_ok = cyc + GAP + 1;
        end else if (pp) begin
            res = 1;
            if (!empty) begin
                contents.delete(mi); m_cnt--; e_read = 1; rv = head;
                next_ok = cyc + GAP + 1;
            end
        end
        if (res) begin e_valid = 1; e_data = rv; end
        else if (e_valid && m_pop_ready) e_valid = 0;
    endtask

    task automatic drive(input bit pv, input logic [DW-1:0] pd, input bit ov, input bit rr);
        s_push_valid = pv; s_push_data = pd; s_pop_valid = ov; m_pop_ready = rr;
        #1;
        model_ready();
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
    endtask

    task automatic wait_accept(input bit pv, input logic [DW-1:0] pd, input bit ov,
                               input bit rr, output bit ok);
        ok = 0;
        for (int n = 0; n < 40; n++) begin
            drive(pv, pd, ov, rr);
            if ((!pv || e_push_ready) && (!ov || e_pop_ready)) begin
                ok = 1;
                return;
            end
            model_step();
            tick();
        end
    endtask

    task automatic do_reset();
        RST = 1; s_push_valid = 0; s_pop_valid = 0; m_pop_ready = 1; full_force = 0;
        tick(); tick();
        RST = 0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if ({q_wrt, q_read, m_pop_valid, o_zero_drop} !== 4'b0) begin fails++;
            $display("FAIL reset_flags: got %b want 0000", {q_wrt, q_read, m_pop_valid, o_zero_drop}); end
        checks++; if (q_data !== '0) begin fails++; $display("FAIL reset_q_data: got %0d want 0", q_data); end
        checks++; if (m_pop_data !== '0) begin fails++; $display("FAIL reset_pop_data: got %0d want 0", m_pop_data); end
        checks++; if (o_count !== '0) begin fails++; $display("FAIL reset_count: got %0d want 0", o_count); end
        drive(0, '0, 0, 1);
        checks++; if (s_push_ready !== 1'b1 || s_pop_ready !== 1'b0) begin fails++;
            $display("FAIL reset_ready: got push %b pop %b want 1 0", s_push_ready, s_pop_ready); end
        model_step(); tick();
    endtask

    task automatic test_push_spacing();
        logic [DW-1:0] vals[3];
        vals[0] = 5; vals[1] = 9; vals[2] = 3;
        for (int k = 0; k < 3; k++) begin
            drive(1, vals[k], 0, 1);
            checks++; if (s_push_ready !== 1'b1) begin fails++; $display("FAIL push_ready_after_gap: got %b want 1", s_push_ready); end
            model_step(); tick();
            checks++; if (q_wrt !== 1'b1 || q_data !== vals[k]) begin fails++;
                $display("FAIL push_cmd: got wrt %b data %0d want 1 %0d", q_wrt, q_data, vals[k]); end
            for (int g = 0; g < GAP; g++) begin
                drive(1, 12'd1, 0, 1);
                checks++; if (s_push_ready !== 1'b0) begin fails++; $display("FAIL push_ready_in_gap: got %b want 0", s_push_ready); end
                model_step(); tick();
                checks++; if (q_wrt !== 1'b0) begin fails++; $display("FAIL push_pulse_width: got wrt %b want 0", q_wrt); end
            end
        end
        checks++; if (o_count !== CW'(3)) begin fails++; $display("FAIL push_count: got %0d want 3", o_count); end
    endtask

    task automatic test_pop_hold();
        drive(0, '0, 1, 0);
        checks++; if (s_pop_ready !== 1'b1) begin fails++; $display("FAIL pop_ready: got %b want 1", s_pop_ready); end
        model_step(); tick();
        checks++; if (q_read !== 1'b1 || m_pop_valid !== 1'b1 || m_pop_data !== 12'd9) begin fails++;
            $display("FAIL pop_cmd: got read %b valid %b data %0d want 1 1 9", q_read, m_pop_valid, m_pop_data); end
        checks++; if (o_count !== CW'(2)) begin fails++; $display("FAIL pop_count: got %0d want 2", o_count); end
        for (int h = 0; h < 3; h++) begin
            drive(0, '0, 1, 0);
            checks++; if (s_pop_ready !== 1'b0) begin fails++; $display("FAIL pop_blocked_while_held: got %b want 0", s_pop_ready); end
            model_step(); tick();
            checks++; if (m_pop_valid !== 1'b1 || m_pop_data !== 12'd9 || q_read !== 1'b0) begin fails++;
                $display("FAIL pop_hold: got valid %b data %0d read %b want 1 9 0", m_pop_valid, m_pop_data, q_read); end
        end
        drive(0, '0, 0, 1); model_step(); tick();
        checks++; if (m_pop_valid !== 1'b0) begin fails++; $display("FAIL pop_release: got %b want 0", m_pop_valid); end
    endtask

    task automatic test_replace();
        bit ok;
        wait_accept(1, 12'd9, 0, 1, ok); model_step(); tick();
        checks++; if (!ok) begin fails++; $display("FAIL replace_setup_timeout: got 0 want 1"); end
        wait_accept(1, 12'd4, 1, 1, ok);
        checks++; if (!ok || s_push_ready !== 1'b1 || s_pop_ready !== 1'b1) begin fails++;
            $display("FAIL replace_ready: got %b%b want 11", s_push_ready, s_pop_ready); end
        model_step(); tick();
        checks++; if (q_wrt !== 1'b1 || q_read !== 1'b1 || q_data !== 12'd4) begin fails++;
            $display("FAIL replace_cmd: got wrt %b read %b data %0d want 1 1 4", q_wrt, q_read, q_data); end
        checks++; if (m_pop_valid !== 1'b1 || m_pop_data !== 12'd9 || o_count !== CW'(3)) begin fails++;
            $display("FAIL replace_result: got valid %b data %0d count %0d want 1 9 3", m_pop_valid, m_pop_data, o_count); end
    endtask

    task automatic test_bypass();
        bit ok;
        wait_accept(1, 12'd9, 0, 1, ok); model_step(); tick();
        checks++; if (!ok) begin fails++; $display("FAIL bypass_setup_timeout: got 0 want 1"); end
        wait_accept(1, 12'd12, 1, 1, ok); model_step(); tick();
        checks++; if (!ok || q_wrt !== 1'b0 || q_read !== 1'b0) begin fails++;
            $display("FAIL bypass_no_cmd: got wrt %b read %b want 0 0", q_wrt, q_read); end
        checks++; if (m_pop_valid !== 1'b1 || m_pop_data !== 12'd12 || o_count !== CW'(4)) begin fails++;
            $display("FAIL bypass_result: got valid %b data %0d count %0d want 1 12 4", m_pop_valid, m_pop_data, o_count); end
        drive(0, '0, 0, 1);
        checks++; if (s_push_ready !== 1'b1) begin fails++; $display("FAIL bypass_no_cool: got %b want 1", s_push_ready); end
        model_step(); tick();
    endtask

    task automatic test_empty_bypass();
        do_reset();
        drive(1, 12'd7, 1, 1);
        checks++; if (s_push_ready !== 1'b1 || s_pop_ready !== 1'b1) begin fails++;
            $display("FAIL empty_bypass_ready: got %b%b want 11", s_push_ready, s_pop_ready); end
        model_step(); tick();
        checks++; if (m_pop_valid !== 1'b1 || m_pop_data !== 12'd7 || q_wrt !== 1'b0 || o_count !== '0) begin fails++;
            $display("FAIL empty_bypass: got valid %b data %0d wrt %b count %0d want 1 7 0 0", m_pop_valid, m_pop_data, q_wrt, o_count); end
        drive(0, '0, 1, 1);
        checks++; if (s_pop_ready !== 1'b0) begin fails++; $display("FAIL empty_pop_ready: got %b want 0", s_pop_ready); end
        model_step(); tick();
    endtask

    task automatic test_zero_drop();
        bit ok;
        wait_accept(1, 12'd3, 0, 1, ok); model_step(); tick();
        wait_accept(1, 12'd0, 0, 1, ok); model_step(); tick();
        checks++; if (!ok || o_zero_drop !== 1'b1 || q_wrt !== 1'b0 || o_count !== CW'(1)) begin fails++;
            $display("FAIL zero_drop: got drop %b wrt %b count %0d want 1 0 1", o_zero_drop, q_wrt, o_count); end
        drive(0, '0, 0, 1);
        checks++; if (s_push_ready !== 1'b1) begin fails++; $display("FAIL zero_no_cool: got %b want 1", s_push_ready); end
        model_step(); tick();
        checks++; if (o_zero_drop !== 1'b0) begin fails++; $display("FAIL zero_pulse_width: got %b want 0", o_zero_drop); end
        drive(1, 12'd0, 1, 1); model_step(); tick();
        checks++; if (q_read !== 1'b1 || q_wrt !== 1'b0 || o_zero_drop !== 1'b1 || m_pop_data !== 12'd3 || o_count !== '0) begin fails++;
            $display("FAIL zero_with_pop: got read %b wrt %b drop %b data %0d count %0d want 1 0 1 3 0",
                     q_read, q_wrt, o_zero_drop, m_pop_data, o_count); end
    endtask

    task automatic test_full();
        bit ok;
        do_reset();
        for (int i = 0; i < QS; i++) begin
            wait_accept(1, DW'($urandom_range(2, 4000)), 0, 1, ok);
            checks++; if (!ok) begin fails++; $display("FAIL fill_timeout: entry %0d", i); break; end
            model_step(); tick();
        end
        checks++; if (o_count !== CW'(QS)) begin fails++; $display("FAIL fill_count: got %0d want %0d", o_count, QS); end
        for (int i = 0; i < GAP + 3; i++) begin
            drive(1, 12'd5, 0, 1);
            checks++; if (s_push_ready !== 1'b0) begin fails++; $display("FAIL full_push_blocked: got %b want 0", s_push_ready); end
            model_step(); tick();
        end
        wait_accept(1, 12'd1, 1, 1, ok); model_step(); tick();
        checks++; if (!ok || q_wrt !== 1'b1 || q_read !== 1'b1 || o_count !== CW'(QS)) begin fails++;
            $display("FAIL full_replace: got wrt %b read %b count %0d want 1 1 %0d", q_wrt, q_read, o_count, QS); end
        do_reset();
        full_force = 1;
        drive(1, 12'd5, 0, 1);
        checks++; if (s_push_ready !== 1'b0) begin fails++; $display("FAIL q_full_blocks_push: got %b want 0", s_push_ready); end
        model_step(); tick();
        full_force = 0;
    endtask

    task automatic test_reset_mid_cool();
        bit ok;
        wait_accept(1, 12'd8, 0, 1, ok); model_step(); tick();
        wait_accept(0, '0, 1, 0, ok); model_step(); tick();
        checks++; if (!ok || m_pop_valid !== 1'b1) begin fails++; $display("FAIL midcool_setup: got valid %b want 1", m_pop_valid); end
        RST = 1; s_pop_valid = 0; m_pop_ready = 0;
        tick();
        RST = 0;
        model_reset();
        checks++; if ({q_wrt, q_read, m_pop_valid, o_zero_drop} !== 4'b0 || o_count !== '0 || m_pop_data !== '0) begin fails++;
            $display("FAIL midcool_reset: got flags %b count %0d data %0d want 0000 0 0",
                     {q_wrt, q_read, m_pop_valid, o_zero_drop}, o_count, m_pop_data); end
        drive(1, 12'd2, 0, 1);
        checks++; if (s_push_ready !== 1'b1) begin fails++; $display("FAIL midcool_abort: got %b want 1", s_push_ready); end
        model_step(); tick();
    endtask

    task automatic test_random();
        bit pv, ov, rr;
        logic [DW-1:0] d;
        do_reset();
        for (int n = 0; n < 700; n++) begin
            pv = ($urandom_range(0, 99) < 62);
            ov = ($urandom_range(0, 99) < 35);
            rr = ($urandom_range(0, 99) < 70);
            d  = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom_range(1, 60));
            drive(pv, d, ov, rr);
            checks++; if (s_push_ready !== e_push_ready || s_pop_ready !== e_pop_ready) begin fails++;
                $display("FAIL rand_ready cyc %0d: got %b%b want %b%b", cyc, s_push_ready, s_pop_ready, e_push_ready, e_pop_ready); end
            model_step(); tick();
            checks++; if (q_wrt !== e_wrt || q_read !== e_read || (e_wrt && q_data !== e_qdata) || o_zero_drop !== e_drop) begin fails++;
                $display("FAIL rand_cmd cyc %0d: got %b%b %0d %b want %b%b %0d %b", cyc,
                         q_wrt, q_read, q_data, o_zero_drop, e_wrt, e_read, e_qdata, e_drop); end
            checks++; if (m_pop_valid !== e_valid || (e_valid && m_pop_data !== e_data) || o_count !== CW'(m_cnt)) begin fails++;
                $display("FAIL rand_result cyc %0d: got %b %0d cnt %0d want %b %0d cnt %0d", cyc,
                         m_pop_valid, m_pop_data, o_count, e_valid, e_data, m_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_push_spacing();
        test_pop_hold();
        test_replace();
        test_bypass();
        test_empty_bypass();
        test_zero_drop();
        test_full();
        test_reset_mid_cool();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
